// File: rtl/enc_dec_slave_link.sv
// Serial slave endpoint: shifts in {msg,key} on Mosi, hands them to the cipher core,
// and streams the core result back on Miso. Optional build macro: MISO_TRISTATE_EN.
module enc_dec_slave_link #(
  parameter int unsigned nk = 8,
  parameter int unsigned nb = 4,
  parameter int unsigned nr = 14
) (
  input  logic                in_clk,
  input  logic                rst,
  input  logic                cs_enc_dec,
  input  logic                Mosi,
  output logic                Miso,
  output logic [32*nb-1:0]    msg_out,
  output logic [32*nk-1:0]    key_out,
  output logic                core_start,
  input  logic                core_done,
  input  logic [32*nb-1:0]    core_result,
  output logic                busy,
  output logic                abort
);

  localparam int unsigned MSG_W = 32 * nb;
  localparam int unsigned KEY_W = 32 * nk;
  localparam int unsigned TOT_W = MSG_W + KEY_W;
  localparam int unsigned RX_CW = $clog2(TOT_W);
  localparam int unsigned TX_CW = $clog2(MSG_W + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RECV  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] SEND  = 3'd4;
  localparam logic [2:0] HOLD  = 3'd5;

  // nr only configures the core; reject configurations the link cannot carry
  if (nr == 0 || nk == 0 || nb == 0) begin : g_cfg_err
    $error("enc_dec_slave_link: nk, nb and nr must be non-zero");
  end

  logic [2:0]       state_q, state_d;
  logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [TOT_W-2:0] sr_q, sr_d;
  logic [MSG_W-2:0] tx_q, tx_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             start_q, start_d;
  logic             abort_q, abort_d;
  logic             busy_q, busy_d;
  logic             miso_q, miso_d;
  logic [TOT_W-1:0] rx_full_c;
  logic             in_txn_c;

  assign rx_full_c = {sr_q, Mosi};
  assign in_txn_c  = (state_q == RECV) || (state_q == START) ||
                     (state_q == WAIT) || (state_q == SEND);

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    rx_cnt_d = rx_cnt_q;
    tx_cnt_d = tx_cnt_q;
    sr_d     = sr_q;
    tx_d     = tx_q;
    msg_d    = msg_q;
    key_d    = key_q;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    miso_d   = miso_q;

    case (state_q)
      IDLE: begin
        if (!cs_enc_dec) begin
          sr_d     = {(TOT_W-2)'(0), Mosi};
          rx_cnt_d = RX_CW'(1);
          state_d  = RECV;
        end
      end
      RECV: begin
        sr_d = rx_full_c[TOT_W-2:0];
        if (rx_cnt_q == RX_CW'(TOT_W - 1)) begin
          msg_d    = rx_full_c[TOT_W-1:KEY_W];
          key_d    = rx_full_c[KEY_W-1:0];
          start_d  = 1'b1;
          rx_cnt_d = '0;
          state_d  = START;
        end else begin
          rx_cnt_d = rx_cnt_q + RX_CW'(1);
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (core_done) begin
          tx_d     = core_result[MSG_W-2:0];
          miso_d   = core_result[MSG_W-1];
          tx_cnt_d = TX_CW'(1);
          state_d  = SEND;
        end
      end
      SEND: begin
        if (tx_cnt_q == TX_CW'(MSG_W)) begin
          miso_d   = 1'b0;
          tx_cnt_d = '0;
          tx_d     = '0;
          state_d  = HOLD;
        end else begin
          miso_d   = tx_q[MSG_W-2];
          tx_d     = {tx_q[MSG_W-3:0], 1'b0};
          tx_cnt_d = tx_cnt_q + TX_CW'(1);
        end
      end
      HOLD: begin
        if (cs_enc_dec) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Chip-select release mid-transaction overrides everything, including core_done
    if (in_txn_c && cs_enc_dec) begin
      state_d  = IDLE;
      abort_d  = 1'b1;
      start_d  = 1'b0;
      rx_cnt_d = '0;
      tx_cnt_d = '0;
      sr_d     = '0;
      tx_d     = '0;
      miso_d   = 1'b0;
      msg_d    = msg_q;
      key_d    = key_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
      sr_q     <= '0;
      tx_q     <= '0;
      msg_q    <= '0;
      key_q    <= '0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      busy_q   <= 1'b0;
      miso_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      sr_q     <= sr_d;
      tx_q     <= tx_d;
      msg_q    <= msg_d;
      key_q    <= key_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
      busy_q   <= busy_d;
      miso_q   <= miso_d;
    end
  end

  assign msg_out    = msg_q;
  assign key_out    = key_q;
  assign core_start = start_q;
  assign abort      = abort_q;
  assign busy       = busy_q;

`ifdef MISO_TRISTATE_EN
  // Only SEND holds a driven bit; the line is released otherwise
  assign Miso = (state_q == SEND) ? miso_q : 1'bz;
`else
  assign Miso = miso_q;
`endif

endmodule

// File: tb/tb_enc_dec_slave_link.sv
// Directed bench for enc_dec_slave_link: FIPS-197 C.3 vectors, abort cases,
// async reset mid-stream and back-to-back transactions.
module tb_enc_dec_slave_link;

  localparam int unsigned MSG_W = 128;
  localparam int unsigned KEY_W = 256;

`ifdef MISO_TRISTATE_EN
  localparam logic IDLE_MISO = 1'bz;
`else
  localparam logic IDLE_MISO = 1'b0;
`endif

  localparam logic [MSG_W-1:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [KEY_W-1:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [MSG_W-1:0] CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic             in_clk;
  logic             rst;
  logic             cs_enc_dec;
  logic             Mosi;
  logic             Miso;
  logic [MSG_W-1:0] msg_out;
  logic [KEY_W-1:0] key_out;
  logic             core_start;
  logic             core_done;
  logic [MSG_W-1:0] core_result;
  logic             busy;
  logic             abort;

  int n_tests = 0;
  int n_fail  = 0;

  enc_dec_slave_link #(.nk(8), .nb(4), .nr(14)) dut (
    .in_clk      (in_clk),
    .rst         (rst),
    .cs_enc_dec  (cs_enc_dec),
    .Mosi        (Mosi),
    .Miso        (Miso),
    .msg_out     (msg_out),
    .key_out     (key_out),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_result (core_result),
    .busy        (busy),
    .abort       (abort)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  // Shift {m,k} MSB first; leaves the DUT in WAIT one edge after core_start
  task automatic run_rx(input logic [MSG_W-1:0] m, input logic [KEY_W-1:0] k, input string tag);
    logic [383:0] v;
    v = {m, k};
    for (int i = 0; i < 384; i++) begin
      cs_enc_dec = 1'b0;
      Mosi = v[383-i];
      tick();
      if (i == 0)   chk({tag, "_busy_first"}, 384'(busy), 384'(1'b1));
      if (i == 382) chk({tag, "_start_early"}, 384'(core_start), 384'(1'b0));
      if (i == 383) chk({tag, "_start_384"}, 384'(core_start), 384'(1'b1));
    end
    chk({tag, "_msg"}, 384'(msg_out), 384'(m));
    chk({tag, "_key"}, 384'(key_out), 384'(k));
    Mosi = 1'b0;
    tick();
    chk({tag, "_start_1cyc"}, 384'(core_start), 384'(1'b0));
  endtask

  // Core model: result after 20 cycles, then collect the 128-bit Miso stream
  task automatic serve(input logic [MSG_W-1:0] res, input string tag);
    logic [MSG_W-1:0] rxv;
    for (int i = 0; i < 19; i++) tick();
    chk({tag, "_miso_wait"}, 384'(Miso), 384'(IDLE_MISO));
    core_done   = 1'b1;
    core_result = res;
    tick();
    core_done = 1'b0;
    rxv[MSG_W-1] = Miso;
    for (int i = 1; i < MSG_W; i++) begin
      tick();
      rxv[MSG_W-1-i] = Miso;
    end
    chk({tag, "_miso_stream"}, 384'(rxv), 384'(res));
    tick();
    chk({tag, "_miso_idle"}, 384'(Miso), 384'(IDLE_MISO));
    chk({tag, "_busy_hold"}, 384'(busy), 384'(1'b1));
    tick();
    chk({tag, "_busy_hold2"}, 384'(busy), 384'(1'b1));
    cs_enc_dec = 1'b1;
    tick();
    chk({tag, "_idle_busy"}, 384'(busy), 384'(1'b0));
    chk({tag, "_idle_noabort"}, 384'(abort), 384'(1'b0));
  endtask

  initial begin
    logic seen_start;
    rst = 1'b0;
    cs_enc_dec = 1'b1;
    Mosi = 1'b0;
    core_done = 1'b0;
    core_result = '0;
    #12;
    chk("rst_busy", 384'(busy), 384'(1'b0));
    chk("rst_start", 384'(core_start), 384'(1'b0));
    chk("rst_abort", 384'(abort), 384'(1'b0));
    chk("rst_msg", 384'(msg_out), 384'(0));
    chk("rst_key", 384'(key_out), 384'(0));
    chk("rst_miso", 384'(Miso), 384'(IDLE_MISO));
    #1 rst = 1'b1;
    tick();
    chk("idle_cs_high", 384'(busy), 384'(1'b0));

    // FIPS-197 C.3 transaction, then back-to-back after a single cs-high edge
    run_rx(PT, KEY, "t1");
    serve(CT, "t1");
    run_rx(CT, ~KEY, "t2");
    serve(PT, "t2");

    // Abort after 100 received bits
    seen_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cs_enc_dec = 1'b0;
      Mosi = 1'b1;
      tick();
      seen_start |= core_start;
    end
    cs_enc_dec = 1'b1;
    tick();
    chk("ab100_abort", 384'(abort), 384'(1'b1));
    chk("ab100_busy", 384'(busy), 384'(1'b0));
    chk("ab100_nostart", 384'(seen_start | core_start), 384'(1'b0));
    chk("ab100_msg_kept", 384'(msg_out), 384'(CT));
    tick();
    chk("ab100_pulse", 384'(abort), 384'(1'b0));

    // cs release on the same edge as core_done
    run_rx(PT, KEY, "t3");
    tick();
    cs_enc_dec  = 1'b1;
    core_done   = 1'b1;
    core_result = CT;
    tick();
    core_done = 1'b0;
    chk("same_abort", 384'(abort), 384'(1'b1));
    chk("same_miso", 384'(Miso), 384'(IDLE_MISO));
    chk("same_busy", 384'(busy), 384'(1'b0));
    tick();
    chk("same_miso2", 384'(Miso), 384'(IDLE_MISO));
    chk("same_pulse", 384'(abort), 384'(1'b0));

    // Asynchronous reset at bit 40 of SEND
    run_rx(CT, KEY, "t4");
    for (int i = 0; i < 19; i++) tick();
    core_done   = 1'b1;
    core_result = PT;
    tick();
    core_done = 1'b0;
    for (int i = 1; i < 40; i++) tick();
    chk("t4_bit40", 384'(Miso), 384'(PT[MSG_W-40]));
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 384'(busy), 384'(1'b0));
    chk("arst_msg", 384'(msg_out), 384'(0));
    chk("arst_key", 384'(key_out), 384'(0));
    chk("arst_start", 384'(core_start), 384'(1'b0));
    chk("arst_miso", 384'(Miso), 384'(IDLE_MISO));
    cs_enc_dec = 1'b1;
    #1 rst = 1'b1;
    tick();
    chk("arst_idle", 384'(busy), 384'(1'b0));
    run_rx(PT, KEY, "t5");
    serve(CT, "t5");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
